// File: rtl/ddr4_fine_sweep.sv
// ddr4_fine_sweep: per-lane fine delay sweep that records the widest passing read window.
// Latency: result pulse DELAY_TAPS*(SETTLE_CYCLES+SAMPLES_PER_TAP+1)+1 cycles after the start edge.
// Backpressure: none; read_ok is sampled unconditionally in SAMPLE. DDR4_FINE_TAPCOUNT_EN adds pass_taps.
module ddr4_fine_sweep #(
    parameter int LANES              = 16,
    parameter int DELAY_TAPS         = 64,
    parameter int SAMPLES_PER_TAP    = 8,
    parameter int PASS_THRESHOLD     = 7,
    parameter int SETTLE_CYCLES      = 16,
    parameter int MIN_GROUP_WIDTH    = 6,
    parameter int MIN_LANES_REQUIRED = 12,
    localparam int TW = $clog2(DELAY_TAPS),
    localparam int WW = $clog2(DELAY_TAPS + 1),
    localparam int SW = $clog2(SAMPLES_PER_TAP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fine_start,
    input  logic [LANES-1:0] read_ok,
    output logic [TW-1:0]    sweep_tap,
    output logic             busy,
    output logic             fine_done,
    output logic             fine_failed,
    output logic [LANES-1:0] lane_valid,
    output logic [TW-1:0]    best_start [0:LANES-1],
    output logic [TW-1:0]    best_end   [0:LANES-1],
    output logic [WW-1:0]    best_width [0:LANES-1]
`ifdef DDR4_FINE_TAPCOUNT_EN
    ,
    output logic [WW-1:0]    pass_taps  [0:LANES-1]
`endif
);
    localparam int CW = $clog2(SETTLE_CYCLES + SAMPLES_PER_TAP + 1);
    localparam int LW = $clog2(LANES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES_PER_TAP - 1);
    localparam logic [TW-1:0] TAP_LAST    = TW'(DELAY_TAPS - 1);
    localparam logic [SW-1:0] THRESH      = SW'(PASS_THRESHOLD);
    localparam logic [WW-1:0] MIN_W       = WW'(MIN_GROUP_WIDTH);
    localparam logic [LW-1:0] MIN_L       = LW'(MIN_LANES_REQUIRED);

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EVAL, FINISH} state_t;

    state_t           state, state_nxt;
    logic             start_armed;
    logic             start_edge;
    logic [CW-1:0]    phase_cnt;
    logic [SW-1:0]    pass_cnt  [0:LANES-1];
    logic [TW-1:0]    cur_start [0:LANES-1];
    logic [WW-1:0]    cur_len   [0:LANES-1];
    logic [LANES-1:0] valid_nxt;
    logic [LW-1:0]    valid_cnt;

    // start_armed means fine_start was seen low; it resets low so a level held through reset never starts.
    assign start_edge = fine_start && start_armed;
    assign busy       = (state != IDLE) || fine_done || fine_failed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_edge) state_nxt = SETTLE;
            SETTLE:  if (phase_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE:  if (phase_cnt == SAMPLE_LAST) state_nxt = EVAL;
            EVAL:    state_nxt = (sweep_tap == TAP_LAST) ? FINISH : SETTLE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = '0;
        valid_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            valid_nxt[l] = (best_width[l] >= MIN_W);
            valid_cnt    = valid_cnt + LW'(valid_nxt[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_armed <= 1'b0;
            phase_cnt   <= '0;
            sweep_tap   <= '0;
            fine_done   <= 1'b0;
            fine_failed <= 1'b0;
            lane_valid  <= '0;
        end else begin
            start_armed <= !fine_start;
            fine_done   <= 1'b0;
            fine_failed <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    sweep_tap  <= '0;
                    phase_cnt  <= '0;
                    lane_valid <= '0;
                end
                SETTLE: phase_cnt <= (phase_cnt == SETTLE_LAST) ? '0 : phase_cnt + 1'b1;
                SAMPLE: phase_cnt <= (phase_cnt == SAMPLE_LAST) ? '0 : phase_cnt + 1'b1;
                EVAL:   if (sweep_tap != TAP_LAST) sweep_tap <= sweep_tap + 1'b1;
                FINISH: begin
                    lane_valid  <= valid_nxt;
                    fine_done   <= (valid_cnt >= MIN_L);
                    fine_failed <= (valid_cnt < MIN_L);
                end
                default: ;
            endcase
        end
    end

    // Strict '>' on the best update keeps the earliest of equally wide windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                pass_cnt[l]   <= '0;
                cur_start[l]  <= '0;
                cur_len[l]    <= '0;
                best_start[l] <= '0;
                best_end[l]   <= '0;
                best_width[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                case (state)
                    IDLE: if (start_edge) begin
                        pass_cnt[l]   <= '0;
                        cur_start[l]  <= '0;
                        cur_len[l]    <= '0;
                        best_start[l] <= '0;
                        best_end[l]   <= '0;
                        best_width[l] <= '0;
                    end
                    SAMPLE: if (read_ok[l]) pass_cnt[l] <= pass_cnt[l] + 1'b1;
                    EVAL: begin
                        pass_cnt[l] <= '0;
                        if (pass_cnt[l] >= THRESH) begin
                            cur_len[l] <= cur_len[l] + 1'b1;
                            if (cur_len[l] == '0) cur_start[l] <= sweep_tap;
                            if ((cur_len[l] + 1'b1) > best_width[l]) begin
                                best_start[l] <= (cur_len[l] == '0) ? sweep_tap : cur_start[l];
                                best_end[l]   <= sweep_tap;
                                best_width[l] <= cur_len[l] + 1'b1;
                            end
                        end else begin
                            cur_len[l] <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DDR4_FINE_TAPCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) pass_taps[l] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (state == IDLE && start_edge)
                    pass_taps[l] <= '0;
                else if (state == EVAL && pass_cnt[l] >= THRESH)
                    pass_taps[l] <= pass_taps[l] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr4_fine_sweep.sv
// Scoreboarded bench for ddr4_fine_sweep: randomized per-tap sample patterns against a run-length model.
`timescale 1ns/1ps
module tb_ddr4_fine_sweep;
    localparam int LANES   = 16;
    localparam int TAPS    = 64;
    localparam int SPT     = 8;
    localparam int THR     = 7;
    localparam int SETTLE  = 16;
    localparam int MINW    = 6;
    localparam int MINL    = 12;
    localparam int TW      = $clog2(TAPS);
    localparam int WW      = $clog2(TAPS + 1);
    localparam int PER_TAP = SETTLE + SPT + 1;
    localparam int LAT     = TAPS * PER_TAP + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fine_start = 1'b0;
    logic [LANES-1:0] read_ok = '0;
    logic [TW-1:0]    sweep_tap;
    logic             busy, fine_done, fine_failed;
    logic [LANES-1:0] lane_valid;
    logic [TW-1:0]    best_start [0:LANES-1];
    logic [TW-1:0]    best_end   [0:LANES-1];
    logic [WW-1:0]    best_width [0:LANES-1];
`ifdef DDR4_FINE_TAPCOUNT_EN
    logic [WW-1:0]    pass_taps  [0:LANES-1];
`endif

    ddr4_fine_sweep dut (
        .clk(clk), .rst_n(rst_n), .fine_start(fine_start), .read_ok(read_ok),
        .sweep_tap(sweep_tap), .busy(busy), .fine_done(fine_done), .fine_failed(fine_failed),
        .lane_valid(lane_valid), .best_start(best_start), .best_end(best_end),
        .best_width(best_width)
`ifdef DDR4_FINE_TAPCOUNT_EN
        , .pass_taps(pass_taps)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]                due;
        logic                       done;
        logic [LANES-1:0]           lv;
        logic [LANES-1:0][TW-1:0]   bs;
        logic [LANES-1:0][TW-1:0]   be;
        logic [LANES-1:0][WW-1:0]   bw;
        logic [LANES-1:0][WW-1:0]   pt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pc  [LANES][TAPS];   // passing samples per lane/tap
    int   rot [LANES][TAPS];   // placement of those samples within the tap

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic win(input int l, input int lo, input int hi);
        for (int t = lo; t <= hi; t++) pc[l][t] = $urandom_range(SPT, THR);
    endtask

    task automatic gen(input int kind);
        for (int l = 0; l < LANES; l++)
            for (int t = 0; t < TAPS; t++) begin
                pc[l][t]  = $urandom_range(THR - 1, 0);
                rot[l][t] = $urandom_range(SPT - 1, 0);
            end
        case (kind)
            0: for (int l = 0; l < LANES; l++) win(l, 20, 39);
            1: begin
                for (int l = 1; l < LANES; l++) win(l, 20, 39);
                win(0, 5, 9); win(0, 30, 45);
            end
            2: begin
                for (int l = 1; l < LANES; l++) win(l, 20, 39);
                win(0, 0, 9); win(0, 40, 49);
            end
            3: for (int l = 0; l < 12; l++) win(l, 10, 30);
            4: for (int l = 0; l < 11; l++) win(l, 10, 30);
            5: for (int l = 0; l < LANES; l++) for (int t = 0; t < TAPS; t++) pc[l][t] = THR - 1;
            6: for (int l = 0; l < LANES; l++) for (int t = 0; t < TAPS; t++) pc[l][t] = THR;
            default: for (int l = 0; l < LANES; l++) begin
                int n, lo, len;
                n = $urandom_range(3, 0);
                for (int k = 0; k < n; k++) begin
                    lo  = $urandom_range(TAPS - 1, 0);
                    len = $urandom_range(24, 1);
                    win(l, lo, (lo + len - 1 > TAPS - 1) ? TAPS - 1 : lo + len - 1);
                end
            end
        endcase
    endtask

    // Reference: enumerate maximal runs of passing taps, keep the first longest one.
    function automatic exp_t model();
        exp_t e;
        int   nvalid;
        e = '0;
        nvalid = 0;
        for (int l = 0; l < LANES; l++) begin
            int bw, bs, be, tot;
            bw = 0; bs = 0; be = 0; tot = 0;
            for (int s = 0; s < TAPS; s++) begin
                if (pc[l][s] >= THR) begin
                    tot++;
                    if (s == 0 || pc[l][s-1] < THR) begin
                        int e2;
                        e2 = s;
                        while (e2 + 1 < TAPS && pc[l][e2+1] >= THR) e2++;
                        if (e2 - s + 1 > bw) begin
                            bw = e2 - s + 1; bs = s; be = e2;
                        end
                    end
                end
            end
            e.bs[l] = TW'(bs);
            e.be[l] = TW'(be);
            e.bw[l] = WW'(bw);
            e.pt[l] = WW'(tot);
            e.lv[l] = (bw >= MINW);
            if (bw >= MINW) nvalid++;
        end
        e.done = (nvalid >= MINL);
        return e;
    endfunction

    task automatic compare_all(input exp_t e, input string tag, input bit flags);
        if (flags) begin
            chk({tag, "_done"}, fine_done, e.done);
            chk({tag, "_failed"}, fine_failed, !e.done);
        end
        chk({tag, "_lane_valid"}, lane_valid, e.lv);
        for (int l = 0; l < LANES; l++) begin
            chk($sformatf("%s_window_lane%0d", tag, l),
                {best_start[l], best_end[l], best_width[l]}, {e.bs[l], e.be[l], e.bw[l]});
`ifdef DDR4_FINE_TAPCOUNT_EN
            chk($sformatf("%s_pass_taps_lane%0d", tag, l), pass_taps[l], e.pt[l]);
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        int nz;
        nz = 0;
        for (int l = 0; l < LANES; l++)
            if (best_start[l] != 0 || best_end[l] != 0 || best_width[l] != 0) nz++;
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_sweep_tap"}, sweep_tap, '0);
        chk({tag, "_pulses"}, {fine_done, fine_failed}, 2'b00);
        chk({tag, "_lane_valid"}, lane_valid, '0);
        chk({tag, "_best_nonzero_lanes"}, nz, 0);
    endtask

    // Monitor: every result pulse cycle consumes exactly one scoreboard entry.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (rst_n && (fine_done || fine_failed)) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b failed=%0b with no sweep pending", fine_done, fine_failed);
                end else begin
                    m = expq.pop_front();
                    chk("pulse_cycle", cyc, m.due);
                    compare_all(m, "result", 1'b1);
                end
            end
        end
    end

    task automatic run(input int kind, input bit toggle, input int abort_at);
        exp_t e;
        int   k, tap, ph;
        gen(kind);
        e = model();
        @(negedge clk) fine_start = 1'b0;
        @(negedge clk) fine_start = 1'b1;
        @(posedge clk);
        #1;
        e.due = cyc + LAT;
        expq.push_back(e);
        for (int j = 1; j <= LAT; j++) begin
            @(negedge clk);
            k   = j - 1;
            tap = k / PER_TAP;
            ph  = k % PER_TAP;
            if (tap < TAPS && ph >= SETTLE && ph < SETTLE + SPT) begin
                for (int l = 0; l < LANES; l++)
                    read_ok[l] = (((ph - SETTLE) + rot[l][tap]) % SPT) < pc[l][tap];
            end else begin
                read_ok = LANES'($urandom);
            end
            if (toggle && (j % 150) == 0) fine_start = ~fine_start;
            if (j == LAT / 2) chk("busy_mid_sweep", busy, 1'b1);
            if (abort_at != 0 && j == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero("abort");
                void'(expq.pop_back());
                @(negedge clk) rst_n = 1'b1;
                repeat (40) @(negedge clk);
                chk("no_restart_busy", busy, 1'b0);
                chk("no_restart_tap", sweep_tap, '0);
                return;
            end
            @(posedge clk);
        end
        repeat (2) @(negedge clk);
        chk("busy_after_pulse", busy, 1'b0);
        chk("pulse_outstanding", expq.size(), 0);
        expq.delete();
        repeat (5) @(negedge clk);
        compare_all(e, "hold", 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(0, 1'b0, 0);
        run(1, 1'b0, 0);
        run(2, 1'b0, 0);
        run(3, 1'b0, 0);
        run(4, 1'b0, 0);
        run(5, 1'b0, 0);
        run(6, 1'b0, 0);
        for (int r = 0; r < 3; r++) run(7, 1'b0, 0);
        run(7, 1'b1, 0);
        run(7, 1'b0, 500);
        run(0, 1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
